me_block_sched: RTL and testbench
=================================

ME_BLOCK_SCHED -- requirements
Module: me_block_sched

Interface
REQ-001 Parameter ROW_W, default 64, bits per block row (16 pixels x 4 bits).
REQ-002 Parameter ROWS, default 16, rows per block.
REQ-003 Parameter BLK_W, default 6, width of block-column and block-row indices.
REQ-004 Ports (name  direction  width  meaning); clock and reset first; one clock; reset synchronous, active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse that launches a frame pass; sampled only in IDLE.
- nbx  in  BLK_W  block columns minus 1; latched at start.
- nby  in  BLK_W  block rows minus 1; latched at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.
- rd_en  out  1  row read request to both frame memories.
- rd_bx  out  BLK_W  block column of the request.
- rd_by  out  BLK_W  block row of the request.
- rd_row  out  4  row within block, 0..15.
- crt_rd_data  in  ROW_W  current-frame row; valid exactly 1 cycle after rd_en.
- pre_rd_data  in  ROW_W  previous-frame row; valid exactly 1 cycle after rd_en.
- crt_rows  out  ROWS*ROW_W  registered current-block rows to core, row 0 in LSBs.
- pre_rows  out  ROWS*ROW_W  registered previous-block rows to core, row 0 in LSBs.
- core_sad  in  14  core sad_min.
- core_mvx  in  4  core motion_vec_x.
- core_mvy  in  4  core motion_vec_y.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_bx, res_by  out  BLK_W  block coordinates of the result.
- res_sad  out  14  captured SAD.
- res_mvx, res_mvy  out  4  captured motion vector.

Function
REQ-005 FSM states IDLE, LOAD, EVAL, OUT; IDLE->LOAD on start, latching nbx/nby and setting bx=by=0.
REQ-006 LOAD asserts rd_en for 16 consecutive cycles with rd_row 0..15 at the current (bx,by); no gaps.
REQ-007 Read data returning in the cycle after each request is written into row slot rd_row of crt_rows/pre_rows; LOAD->EVAL on the cycle the row-15 data is written (17 cycles in LOAD).
REQ-008 EVAL lasts exactly 1 cycle; at its end core_sad/mvx/mvy and bx/by are registered into res_* and the FSM enters OUT.
REQ-009 OUT asserts res_valid; res_* held stable while res_valid && !res_ready.
REQ-010 On res_valid && res_ready: if bx<nbx, bx+1 -> LOAD; else if by<nby, bx=0, by+1 -> LOAD; else done pulse, -> IDLE.
REQ-011 Per-block latency start-of-LOAD to res_valid = 18 cycles with res_ready held high; block-to-block throughput 19 cycles.
REQ-012 start outside IDLE ignored; nbx=nby=0 processes exactly one block.
REQ-013 Raster order: bx fastest; bx/by never exceed latched nbx/nby.
REQ-014 crt_rows/pre_rows change only during LOAD; stable through EVAL and OUT.

Reset
REQ-015 rst in any state, including mid-LOAD or during OUT backpressure, returns to IDLE next edge; no done pulse.
REQ-016 Reset values: busy, done, rd_en, res_valid = 0; rd_bx, rd_by, rd_row, bx, by, res_* = 0; crt_rows/pre_rows = 0.
REQ-017 Read data arriving the cycle after reset is discarded.

Structure
REQ-018 A shared package holds the FSM state enum, ROW_W, ROWS, BLK_W defaults, SAD width 14 and MV width 4.
REQ-019 One sub-module, me_row_buffer (16-row write-addressed register bank), instantiated twice for the crt and pre rows.

Verification
REQ-020 nbx=0, nby=0, start, res_ready=1: rd_en high 16 cycles, row values 0..15, res_valid at cycle 18 with core values (e.g. sad 0x123, mvx 5, mvy 10); done pulse follows.
REQ-021 nbx=2, nby=1: six results in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); single done after the last.
REQ-022 res_ready low 10 cycles in OUT: res_* stable, no rd_en, advance on the first ready cycle.
REQ-023 rst asserted at LOAD row 7: IDLE next cycle, all outputs at reset values, no done; new start runs cleanly from (0,0).
REQ-024 start pulsed during LOAD and OUT: ignored; result count unchanged.
REQ-025 Distinct per-row memory patterns: crt_rows/pre_rows slot k equals row k data at EVAL.

Source files
------------

// File: rtl/me_block_sched_pkg.sv
// Shared types and default sizes for the motion-estimation block scheduler.
package me_block_sched_pkg;

   localparam int ROW_W_DEF = 64;
   localparam int ROWS_DEF  = 16;
   localparam int BLK_W_DEF = 6;
   localparam int SAD_W     = 14;
   localparam int MV_W      = 4;
   localparam int ROW_IDX_W = 4;
   localparam int CNT_W     = ROW_IDX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EVAL = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/me_row_buffer.sv
// Write-addressed bank of block rows; slot k holds row k, row 0 in the LSBs.
module me_row_buffer
   import me_block_sched_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int ROWS  = ROWS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ROW_IDX_W-1:0]  wr_row,
   input  logic [ROW_W-1:0]      wr_data,
   output logic [ROWS*ROW_W-1:0] rows
);

   // Write the addressed slot; every other slot holds its contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         rows <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < ROWS; k++) begin
            if (wr_row == ROW_IDX_W'(k)) begin
               rows[k*ROW_W +: ROW_W] <= wr_data;
            end
         end
      end
   end

endmodule

// File: rtl/me_block_sched.sv
// Frame-pass scheduler: walks blocks in raster order, fetches 16 rows of the
// current and previous frame per block, hands them to the ME core and
// presents the core result with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | issuing 16 row reads, writing returned rows into the buffers
// EVAL  | one cycle for the core to settle; result captured at its end
// OUT   | result offered downstream, waiting for res_ready
module me_block_sched
   import me_block_sched_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int ROWS  = ROWS_DEF,
   parameter int BLK_W = BLK_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BLK_W-1:0]      nbx,
   input  logic [BLK_W-1:0]      nby,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [BLK_W-1:0]      rd_bx,
   output logic [BLK_W-1:0]      rd_by,
   output logic [ROW_IDX_W-1:0]  rd_row,
   input  logic [ROW_W-1:0]      crt_rd_data,
   input  logic [ROW_W-1:0]      pre_rd_data,
   output logic [ROWS*ROW_W-1:0] crt_rows,
   output logic [ROWS*ROW_W-1:0] pre_rows,
   input  logic [SAD_W-1:0]      core_sad,
   input  logic [MV_W-1:0]       core_mvx,
   input  logic [MV_W-1:0]       core_mvy,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [BLK_W-1:0]      res_bx,
   output logic [BLK_W-1:0]      res_by,
   output logic [SAD_W-1:0]      res_sad,
   output logic [MV_W-1:0]       res_mvx,
   output logic [MV_W-1:0]       res_mvy
);

   // Counter value on which the last row's data lands in the buffers.
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(ROWS);

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [BLK_W-1:0]     bx;
   logic [BLK_W-1:0]     by;
   logic [BLK_W-1:0]     nbx_q;
   logic [BLK_W-1:0]     nby_q;
   logic                 wr_en_q;
   logic [ROW_IDX_W-1:0] wr_row_q;
   logic                 accept;
   logic                 last_blk;

   assign accept   = (state == ST_OUT) && res_ready;
   assign last_blk = (bx == nbx_q) && (by == nby_q);

   assign busy      = (state != ST_IDLE);
   assign res_valid = (state == ST_OUT);
   assign rd_bx     = bx;
   assign rd_by     = by;
   assign rd_row    = cnt[ROW_IDX_W-1:0];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and read-request decode.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            rd_en = (cnt < LOAD_LAST);
            if (cnt == LOAD_LAST) state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            state_nxt = ST_OUT;
         end
         ST_OUT: begin
            if (res_ready) state_nxt = last_blk ? ST_IDLE : ST_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Block walk, row counter, result capture and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         bx      <= '0;
         by      <= '0;
         nbx_q   <= '0;
         nby_q   <= '0;
         done    <= 1'b0;
         res_bx  <= '0;
         res_by  <= '0;
         res_sad <= '0;
         res_mvx <= '0;
         res_mvy <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  nbx_q <= nbx;
                  nby_q <= nby;
                  bx    <= '0;
                  by    <= '0;
                  cnt   <= '0;
               end
            end
            ST_LOAD: begin
               cnt <= cnt + CNT_W'(1);
            end
            ST_EVAL: begin
               res_bx  <= bx;
               res_by  <= by;
               res_sad <= core_sad;
               res_mvx <= core_mvx;
               res_mvy <= core_mvy;
            end
            ST_OUT: begin
               if (accept) begin
                  cnt <= '0;
                  if (bx < nbx_q) begin
                     bx <= bx + BLK_W'(1);
                  end else if (by < nby_q) begin
                     bx <= '0;
                     by <= by + BLK_W'(1);
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Read data returns one cycle after the request; remember where it goes.
   // Clearing on reset drops data that was in flight when reset hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q  <= 1'b0;
         wr_row_q <= '0;
      end else begin
         wr_en_q  <= rd_en;
         wr_row_q <= rd_row;
      end
   end

   me_row_buffer #(
      .ROW_W (ROW_W),
      .ROWS  (ROWS)
   ) u_crt_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_q),
      .wr_row  (wr_row_q),
      .wr_data (crt_rd_data),
      .rows    (crt_rows)
   );

   me_row_buffer #(
      .ROW_W (ROW_W),
      .ROWS  (ROWS)
   ) u_pre_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_q),
      .wr_row  (wr_row_q),
      .wr_data (pre_rd_data),
      .rows    (pre_rows)
   );

endmodule

// File: tb/tb_me_block_sched.sv
// Directed bench for me_block_sched with a one-cycle-latency frame memory model.
module tb_me_block_sched;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [5:0]    nbx;
   logic [5:0]    nby;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [5:0]    rd_bx;
   logic [5:0]    rd_by;
   logic [3:0]    rd_row;
   logic [63:0]   crt_rd_data;
   logic [63:0]   pre_rd_data;
   logic [1023:0] crt_rows;
   logic [1023:0] pre_rows;
   logic [13:0]   core_sad;
   logic [3:0]    core_mvx;
   logic [3:0]    core_mvy;
   logic          res_valid;
   logic          res_ready;
   logic [5:0]    res_bx;
   logic [5:0]    res_by;
   logic [13:0]   res_sad;
   logic [3:0]    res_mvx;
   logic [3:0]    res_mvy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   me_block_sched #(.ROW_W(64), .ROWS(16), .BLK_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .nbx         (nbx),
      .nby         (nby),
      .busy        (busy),
      .done        (done),
      .rd_en       (rd_en),
      .rd_bx       (rd_bx),
      .rd_by       (rd_by),
      .rd_row      (rd_row),
      .crt_rd_data (crt_rd_data),
      .pre_rd_data (pre_rd_data),
      .crt_rows    (crt_rows),
      .pre_rows    (pre_rows),
      .core_sad    (core_sad),
      .core_mvx    (core_mvx),
      .core_mvy    (core_mvy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_bx      (res_bx),
      .res_by      (res_by),
      .res_sad     (res_sad),
      .res_mvx     (res_mvx),
      .res_mvy     (res_mvy)
   );

   function automatic logic [63:0] crt_pat(input logic [5:0] bx, input logic [5:0] by,
                                           input logic [3:0] row);
      return {8'hC1, 2'b00, bx, 2'b00, by, 4'h0, row,
              32'h0101_0101 * (32'(row) + 32'd1)};
   endfunction

   function automatic logic [63:0] pre_pat(input logic [5:0] bx, input logic [5:0] by,
                                           input logic [3:0] row);
      return {4'h7, row, 2'b00, by, 2'b00, bx, 8'h5A,
              32'hFFFF_FFFF - 32'h0011_0011 * 32'(row)};
   endfunction

   // Frame memories: data for a request appears one cycle later; junk otherwise.
   always @(posedge clk) begin
      if (rd_en) begin
         crt_rd_data <= crt_pat(rd_bx, rd_by, rd_row);
         pre_rd_data <= pre_pat(rd_bx, rd_by, rd_row);
      end else begin
         crt_rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
         pre_rd_data <= 64'hBAD0_BAD0_BAD0_BAD0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered at the negedge of LOAD cycle 0; leaves at the negedge of the first OUT cycle.
   task automatic run_block(input logic [5:0] bx, input logic [5:0] by,
                            input logic [13:0] sad, input logic [3:0] mvx,
                            input logic [3:0] mvy, input bit poke_start);
      core_sad = sad;
      core_mvx = mvx;
      core_mvy = mvy;
      for (int k = 0; k < 16; k++) begin
         chk("rd_en", 64'(rd_en), 64'd1);
         chk("rd_row", 64'(rd_row), 64'(k));
         chk("rd_bx", 64'(rd_bx), 64'(bx));
         chk("rd_by", 64'(rd_by), 64'(by));
         chk("busy_load", 64'(busy), 64'd1);
         chk("valid_load", 64'(res_valid), 64'd0);
         start = (poke_start && k == 5);
         @(negedge clk);
      end
      start = 1'b0;
      chk("rd_en_end", 64'(rd_en), 64'd0);
      chk("valid_l16", 64'(res_valid), 64'd0);
      @(negedge clk);
      chk("valid_eval", 64'(res_valid), 64'd0);
      chk("rd_en_eval", 64'(rd_en), 64'd0);
      for (int k = 0; k < 16; k++) begin
         chk("crt_slot", crt_rows[k*64 +: 64], crt_pat(bx, by, 4'(k)));
         chk("pre_slot", pre_rows[k*64 +: 64], pre_pat(bx, by, 4'(k)));
      end
      @(negedge clk);
      chk("res_valid", 64'(res_valid), 64'd1);
      chk("rd_en_out", 64'(rd_en), 64'd0);
      chk("res_bx", 64'(res_bx), 64'(bx));
      chk("res_by", 64'(res_by), 64'(by));
      chk("res_sad", 64'(res_sad), 64'(sad));
      chk("res_mvx", 64'(res_mvx), 64'(mvx));
      chk("res_mvy", 64'(res_mvy), 64'(mvy));
      chk("crt_hold", crt_rows[7*64 +: 64], crt_pat(bx, by, 4'd7));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      nbx       = '0;
      nby       = '0;
      res_ready = 1'b1;
      core_sad  = '0;
      core_mvx  = '0;
      core_mvy  = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_rd_row", 64'(rd_row), 64'd0);
      chk("rst_rd_bx", 64'(rd_bx), 64'd0);
      chk("rst_res_sad", 64'(res_sad), 64'd0);
      chk("rst_crt0", crt_rows[63:0], 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);

      // Single block, latency 18 from start of LOAD to res_valid
      nbx   = 6'd0;
      nby   = 6'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_block(6'd0, 6'd0, 14'h123, 4'd5, 4'd10, 1'b0);
      @(negedge clk);
      chk("done_1", 64'(done), 64'd1);
      chk("busy_1", 64'(busy), 64'd0);
      @(negedge clk);
      chk("done_1_off", 64'(done), 64'd0);

      // 3x2 frame in raster order, back-to-back blocks
      nbx   = 6'd2;
      nby   = 6'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbx   = 6'd0;
      nby   = 6'd0;
      for (int i = 0; i < 6; i++) begin
         run_block(6'(i % 3), 6'(i / 3), 14'(14'h200 + i), 4'(i), 4'(15 - i), 1'b0);
         @(negedge clk);
         if (i < 5) begin
            chk("done_mid", 64'(done), 64'd0);
            chk("busy_mid", 64'(busy), 64'd1);
         end else begin
            chk("done_2", 64'(done), 64'd1);
            chk("busy_2", 64'(busy), 64'd0);
         end
      end
      @(negedge clk);
      chk("done_2_off", 64'(done), 64'd0);

      // Backpressure in OUT with stray start pulses in OUT and LOAD
      nbx       = 6'd1;
      nby       = 6'd0;
      res_ready = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_block(6'd0, 6'd0, 14'h3AB, 4'd7, 4'd9, 1'b1);
      for (int j = 0; j < 10; j++) begin
         chk("bp_valid", 64'(res_valid), 64'd1);
         chk("bp_sad", 64'(res_sad), 64'h3AB);
         chk("bp_mvx", 64'(res_mvx), 64'd7);
         chk("bp_bx", 64'(res_bx), 64'd0);
         chk("bp_rd_en", 64'(rd_en), 64'd0);
         core_sad = 14'h0;
         start    = (j == 3);
         @(negedge clk);
      end
      start     = 1'b0;
      chk("bp_hold", 64'(res_valid), 64'd1);
      res_ready = 1'b1;
      @(negedge clk);
      run_block(6'd1, 6'd0, 14'h0F0, 4'd2, 4'd3, 1'b1);
      @(negedge clk);
      chk("done_3", 64'(done), 64'd1);
      chk("busy_3", 64'(busy), 64'd0);
      @(negedge clk);
      chk("done_3_off", 64'(done), 64'd0);
      chk("idle_3", 64'(busy), 64'd0);

      // Reset at LOAD row 7, then a clean restart
      nbx   = 6'd3;
      nby   = 6'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_rst_row", 64'(rd_row), 64'd7);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_rd_en", 64'(rd_en), 64'd0);
      chk("mid_rd_row", 64'(rd_row), 64'd0);
      chk("mid_done", 64'(done), 64'd0);
      chk("mid_valid", 64'(res_valid), 64'd0);
      chk("mid_res_sad", 64'(res_sad), 64'd0);
      chk("mid_res_mvx", 64'(res_mvx), 64'd0);
      chk("mid_res_bx", 64'(res_bx), 64'd0);
      chk("mid_crt0", crt_rows[0 +: 64], 64'd0);
      chk("mid_pre6", pre_rows[6*64 +: 64], 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("late_crt7", crt_rows[7*64 +: 64], 64'd0);
      chk("late_pre7", pre_rows[7*64 +: 64], 64'd0);
      chk("late_busy", 64'(busy), 64'd0);
      chk("late_done", 64'(done), 64'd0);
      nbx   = 6'd0;
      nby   = 6'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_block(6'd0, 6'd0, 14'h2A5, 4'd15, 4'd0, 1'b0);
      @(negedge clk);
      chk("done_4", 64'(done), 64'd1);
      @(negedge clk);
      chk("done_4_off", 64'(done), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
